regfile_dump_ctrl: RTL and testbench

REGFILE_DUMP_CTRL -- requirements
Module: regfile_dump_ctrl

---
 rtl/regfile_dump_ctrl_if.sv | 42 ++++
 rtl/regfile_dump_ctrl.sv | 139 +++++++++++++
 tb/tb_regfile_dump_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_ctrl_if.sv
// -----------------------------------------------------------------------------
// regfile_dump_ctrl_if
// Bundles the control, register-file read and output stream signals of
// regfile_dump_ctrl.
//   start/abort            dump request and cancel
//   first_addr/last_addr   dump range, sampled with start
//   rf_addr/rf_data        register-file read port (combinational read data)
//   out_valid/out_ready    output beat handshake
//   out_data/out_addr      register contents and index of the beat
//   out_last               beat carries the final register of the range
//   busy/done              status: dump in progress / one-cycle completion pulse
// master: the environment (requester, register file, consumer).
// slave : the dump controller.
// -----------------------------------------------------------------------------
interface regfile_dump_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, first_addr, last_addr, rf_data, out_ready,
    input  rf_addr, out_valid, out_data, out_addr, out_last, busy, done
  );

  modport slave (
    input  start, abort, first_addr, last_addr, rf_data, out_ready,
    output rf_addr, out_valid, out_data, out_addr, out_last, busy, done
  );
endinterface

// File: rtl/regfile_dump_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_dump_ctrl
// Streams a range of register-file entries [first_addr .. last_addr] (wrapping
// modulo 2^ADDR_W) out over a valid/ready channel, one beat per register.
// Ports:
//   clk   clock, all state changes on its rising edge
//   rst   asynchronous active-high reset
//   bus   regfile_dump_ctrl_if.slave: start/abort, range, register-file read
//         port, output stream and busy/done status
// The read pointer drives rf_addr directly; rf_data is captured into the output
// register, so out_data holds the register value as of the capture edge.
// -----------------------------------------------------------------------------
module regfile_dump_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic                 clk,
  input logic                 rst,
  regfile_dump_ctrl_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]        state_q,     state_d;
  logic [ADDR_W-1:0] ptr_q,       ptr_d;
  logic [ADDR_W-1:0] end_q,       end_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic              out_last_q,  out_last_d;
  logic              done_q,      done_d;

  logic capture;
  logic accept;
  logic at_end;

  // A capture refills the output register whenever it is empty or is being
  // drained this cycle, which gives one beat per cycle under constant ready.
  assign accept  = out_valid_q && bus.out_ready;
  assign capture = (state_q == ST_RUN) && (!out_valid_q || bus.out_ready);
  assign at_end  = (ptr_q == end_q);

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path
    // through the case statement leaves one unassigned (which would infer a latch).
    state_d     = state_q;
    ptr_d       = ptr_q;
    end_d       = end_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // done_q marks the cycle right after completion; a start there is
        // treated as belonging to the finished dump and ignored.
        if (bus.start && !done_q) begin
          ptr_d   = bus.first_addr;
          end_d   = bus.last_addr;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (bus.abort) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = ST_IDLE;
        end else if (capture) begin
          out_data_d  = bus.rf_data;
          out_addr_d  = ptr_q;
          out_valid_d = 1'b1;
          out_last_d  = at_end;
          if (at_end) begin
            state_d = ST_DRAIN;
          end else begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end
      end

      ST_DRAIN: begin
        if (bus.abort) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = ST_IDLE;
        end else if (accept) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      end_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the previous state, independent of statement order.
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      end_q       <= end_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign bus.rf_addr   = ptr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_last  = out_last_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// -----------------------------------------------------------------------------
// tb_regfile_dump_ctrl
// Directed bench for regfile_dump_ctrl. A register-file model preloaded with
// reg[i] = i feeds rf_data combinationally. Inputs are driven and outputs
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_regfile_dump_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int BUDGET = 400;

  typedef struct {
    logic [ADDR_W-1:0] first;
    logic [ADDR_W-1:0] last;
    int                stall;      // cycles out_ready stays low per beat
    bit                repulse;    // hold start high while busy and in the done cycle
    int                exp_beats;
  } vec_t;

  logic clk;
  logic rst;
  logic [DATA_W-1:0] rf [32];

  int checks;
  int errors;

  regfile_dump_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_dump_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign bus.rf_data = rf[bus.rf_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_dump(input vec_t v);
    int                beats;
    int                stall_cnt;
    int                cyc;
    logic [ADDR_W-1:0] exp_a;
    logic [DATA_W-1:0] snap_data;
    logic [ADDR_W-1:0] snap_addr;
    logic              snap_last;
    beats     = 0;
    stall_cnt = 0;
    cyc       = 0;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.first_addr = v.first;
    bus.last_addr  = v.last;
    @(negedge clk);
    bus.start = v.repulse;
    if (v.repulse) begin
      bus.first_addr = 5'd0;
      bus.last_addr  = 5'd31;
    end
    check("lat_valid_low", bus.out_valid, 1'b0);
    check("busy_in_run", bus.busy, 1'b1);
    @(negedge clk);
    check("lat_valid_high", bus.out_valid, 1'b1);
    while (beats < v.exp_beats && cyc < BUDGET) begin
      bus.out_ready = (stall_cnt >= v.stall);
      check("valid_held", bus.out_valid, 1'b1);
      check("no_early_done", bus.done, 1'b0);
      if (!bus.out_ready) begin
        if (stall_cnt == 0) begin
          snap_data = bus.out_data;
          snap_addr = bus.out_addr;
          snap_last = bus.out_last;
        end else begin
          check("stall_data", bus.out_data, snap_data);
          check("stall_addr", bus.out_addr, snap_addr);
          check("stall_last", bus.out_last, snap_last);
        end
        stall_cnt++;
      end else begin
        exp_a = v.first + beats[ADDR_W-1:0];
        check("beat_addr", bus.out_addr, exp_a);
        check("beat_data", bus.out_data, rf[exp_a]);
        check("beat_last", bus.out_last, (beats == v.exp_beats - 1));
        beats++;
        stall_cnt = 0;
      end
      @(negedge clk);
      cyc++;
    end
    check("beat_count", beats, v.exp_beats);
    bus.out_ready = 1'b1;
    check("done_pulse", bus.done, 1'b1);
    check("valid_after_done", bus.out_valid, 1'b0);
    check("last_after_done", bus.out_last, 1'b0);
    check("busy_after_done", bus.busy, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    check("done_one_cycle", bus.done, 1'b0);
    check("idle_after_done", bus.busy, 1'b0);
    check("no_restart_valid", bus.out_valid, 1'b0);
  endtask

  vec_t vecs [4];

  initial begin
    int                n;
    int                cyc;
    logic [DATA_W-1:0] exp_d [4];

    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) rf[i] = DATA_W'(i);

    vecs[0] = '{first: 5'd0,  last: 5'd31, stall: 0, repulse: 1'b0, exp_beats: 32};
    vecs[1] = '{first: 5'd30, last: 5'd1,  stall: 0, repulse: 1'b0, exp_beats: 4};
    vecs[2] = '{first: 5'd5,  last: 5'd7,  stall: 3, repulse: 1'b0, exp_beats: 3};
    vecs[3] = '{first: 5'd9,  last: 5'd9,  stall: 0, repulse: 1'b1, exp_beats: 1};

    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.first_addr = '0;
    bus.last_addr  = '0;
    bus.out_ready  = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", bus.out_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_rf_addr", bus.rf_addr, 5'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_start", bus.busy, 1'b0);

    foreach (vecs[i]) run_dump(vecs[i]);

    // Abort after the second beat of 0..31, with out_ready high in the abort cycle.
    @(negedge clk);
    bus.start      = 1'b1;
    bus.first_addr = 5'd0;
    bus.last_addr  = 5'd31;
    bus.out_ready  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n   = 0;
    cyc = 0;
    while (n < 2 && cyc < BUDGET) begin
      if (bus.out_valid && bus.out_ready) n++;
      @(negedge clk);
      cyc++;
    end
    check("abort_pre_beats", n, 2);
    check("abort_pre_addr", bus.out_addr, 5'd2);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_valid", bus.out_valid, 1'b0);
    check("abort_last", bus.out_last, 1'b0);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_no_done", bus.done, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("abort_quiet_done", bus.done, 1'b0);
      check("abort_quiet_valid", bus.out_valid, 1'b0);
    end

    // Abort in IDLE is ignored; the simultaneous start still launches a dump.
    bus.abort      = 1'b1;
    bus.start      = 1'b1;
    bus.first_addr = 5'd20;
    bus.last_addr  = 5'd20;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check("idle_abort_busy", bus.busy, 1'b1);
    @(negedge clk);
    check("idle_abort_valid", bus.out_valid, 1'b1);
    check("idle_abort_data", bus.out_data, 32'd20);
    @(negedge clk);
    check("idle_abort_done", bus.done, 1'b1);
    @(negedge clk);

    // Reset in the middle of a stalled dump.
    bus.out_ready  = 1'b0;
    bus.start      = 1'b1;
    bus.first_addr = 5'd3;
    bus.last_addr  = 5'd31;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("pre_rst_data", bus.out_data, 32'd3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", bus.out_valid, 1'b0);
    check("mid_rst_data", bus.out_data, 32'd0);
    check("mid_rst_addr", bus.out_addr, 5'd0);
    check("mid_rst_last", bus.out_last, 1'b0);
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_done", bus.done, 1'b0);
    check("mid_rst_rf_addr", bus.rf_addr, 5'd0);
    @(negedge clk);
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_idle", bus.busy, 1'b0);
    run_dump('{first: 5'd7, last: 5'd8, stall: 0, repulse: 1'b0, exp_beats: 2});

    // Register-file writes during a dump: an already captured register keeps
    // its old value, a not-yet-captured one shows the new value.
    bus.out_ready  = 1'b0;
    bus.start      = 1'b1;
    bus.first_addr = 5'd10;
    bus.last_addr  = 5'd13;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("wr_first_valid", bus.out_valid, 1'b1);
    rf[10]   = 32'hEE;
    rf[12]   = 32'hA5;
    exp_d[0] = 32'd10;
    exp_d[1] = 32'd11;
    exp_d[2] = 32'hA5;
    exp_d[3] = 32'd13;
    bus.out_ready = 1'b1;
    n   = 0;
    cyc = 0;
    while (n < 4 && cyc < BUDGET) begin
      if (bus.out_valid) begin
        check("wr_beat_data", bus.out_data, exp_d[n]);
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    check("wr_beat_count", n, 4);
    check("wr_done", bus.done, 1'b1);
    rf[10] = 32'd10;
    rf[12] = 32'd12;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
